shift_mult_unit: RTL and testbench
==================================

Name: shift_mult_unit

Overview:
- Registered datapath slice that sits beside the CPU ALU and provides the shift and multiply results.
- Each operation uses DATA1 as the operand and DATA2 as the shift amount or multiplicand.
- The unit computes the barrel-shift result and the truncated product in parallel.
- Both results are registered and appear one clock after the operands are accepted.
- The ALU selects between them with its own ALUOP mux: shift result for ALUOP=3'b100, product for ALUOP=3'b101.

Parameters:
- WIDTH, 8, operand/result width; must be a power of two, at least 4.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operands valid this cycle; the unit captures them on the next rising edge.
- DATA1  input  WIDTH  value to shift; multiplier operand A.
- DATA2  input  WIDTH  shift amount (unsigned); multiplier operand B.
- SHIFTOP  input  2  shift type: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- SHIFT_RESULT  output  WIDTH  registered shift result.
- PRODUCT  output  WIDTH  registered low WIDTH bits of DATA1*DATA2 (unsigned).
- OUT_VALID  output  1  SHIFT_RESULT/PRODUCT hold a freshly computed result.

Behaviour:
- Reset:
  - RESET low forces SHIFT_RESULT=0, PRODUCT=0 and OUT_VALID=0 immediately, without waiting for a clock edge.
  - The outputs stay at these values while RESET is low.
- Latency and hold:
  - Fixed latency of 1 cycle, no stall and no backpressure.
  - On a rising edge with IN_VALID=1, both results are computed combinationally from the current inputs and registered; OUT_VALID becomes 1.
  - On a rising edge with IN_VALID=0, OUT_VALID becomes 0 and both result registers hold their previous values.
  - Back-to-back valid inputs produce back-to-back results, one per cycle.
- Barrel shifter structure:
  - log2(WIDTH) mux stages (1, 2, 4, ... positions).
  - Each stage is controlled by one bit of DATA2[log2(WIDTH)-1:0].
- Shift amounts of WIDTH or more (any upper DATA2 bit set):
  - Logical left: result 0.
  - Logical right: result 0.
  - Arithmetic right: every bit equals DATA1[WIDTH-1].
  - Rotate right: uses amount mod WIDTH.
- A shift amount of 0 returns DATA1 unchanged for every SHIFTOP.
- Multiplier:
  - Unsigned shift-and-add or array multiplier; no `*` operator in the datapath.
  - Result truncated to the low WIDTH bits; overflow silently discarded.
- Operand corner cases: any operand 0 gives PRODUCT 0; an operand of 1 gives PRODUCT equal to the other operand.
- Both results are always computed; there is no operation select inside the unit.

Optional Feature:
- Macro: PRODUCT_HI_EN.
- When defined, two extra outputs are added:
  - PRODUCT_HI (WIDTH bits): registered upper half of the 2*WIDTH-bit product. Reset value 0; same capture and hold rules as PRODUCT.
  - MUL_OVF (1 bit): 1 when PRODUCT_HI is non-zero.
- When undefined, neither port exists and the upper product bits are never formed.

Test Plan:
- Reset:
  - Stimulus: RESET=0 asynchronously mid-cycle while OUT_VALID=1 and the outputs are non-zero.
  - Required: SHIFT_RESULT=0x00, PRODUCT=0x00, OUT_VALID=0 immediately, and they stay there until RESET=1 and a valid input is captured.
- Logical left, in-range amount:
  - Stimulus: DATA1=0x81, DATA2=0x03, SHIFTOP=00, IN_VALID=1.
  - Required, next edge: SHIFT_RESULT=0x08, PRODUCT=0x83, OUT_VALID=1.
- Right shifts and rotate, DATA1=0x81, DATA2=3, one op per cycle:
  - SHIFTOP=01 -> 0x10.
  - SHIFTOP=10 -> 0xF0.
  - SHIFTOP=11 -> 0x30.
  - Each result arrives one cycle after its input.
- Shift amount 9, DATA1=0x81:
  - SHIFTOP=00 -> 0x00.
  - SHIFTOP=01 -> 0x00.
  - SHIFTOP=10 -> 0xFF.
  - SHIFTOP=11 -> 0xC0.
  - Shift amount 0 with SHIFTOP=10 -> 0x81.
- Multiply overflow:
  - Stimulus: 0x10*0x10.
  - Required: PRODUCT=0x00; with PRODUCT_HI_EN also PRODUCT_HI=0x01 and MUL_OVF=1.
  - Stimulus: 0xFF*0x01.
  - Required: PRODUCT=0xFF and MUL_OVF=0.
- Hold behaviour:
  - Stimulus: IN_VALID=0 for 2 cycles after a valid op.
  - Required: OUT_VALID=0 and both results unchanged.

Source files
------------

// File: rtl/shift_mult_unit_if.sv
// Operand/result bundle between the ALU and shift_mult_unit; WIDTH must match the unit.
// With PRODUCT_HI_EN defined the bundle also carries PRODUCT_HI and MUL_OVF.
interface shift_mult_unit_if #(parameter int WIDTH = 8);
  logic             IN_VALID;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [1:0]       SHIFTOP;
  logic [WIDTH-1:0] SHIFT_RESULT;
  logic [WIDTH-1:0] PRODUCT;
  logic             OUT_VALID;
`ifdef PRODUCT_HI_EN
  logic [WIDTH-1:0] PRODUCT_HI;
  logic             MUL_OVF;

  modport master (
    output IN_VALID, DATA1, DATA2, SHIFTOP,
    input  SHIFT_RESULT, PRODUCT, OUT_VALID, PRODUCT_HI, MUL_OVF
  );
  modport slave (
    input  IN_VALID, DATA1, DATA2, SHIFTOP,
    output SHIFT_RESULT, PRODUCT, OUT_VALID, PRODUCT_HI, MUL_OVF
  );
`else
  modport master (
    output IN_VALID, DATA1, DATA2, SHIFTOP,
    input  SHIFT_RESULT, PRODUCT, OUT_VALID
  );
  modport slave (
    input  IN_VALID, DATA1, DATA2, SHIFTOP,
    output SHIFT_RESULT, PRODUCT, OUT_VALID
  );
`endif
endinterface

// File: rtl/shift_mult_unit.sv
// Barrel shift + truncated unsigned multiply, both registered with 1-cycle latency, no backpressure.
// Define PRODUCT_HI_EN to also register the upper product half (PRODUCT_HI) and flag MUL_OVF.
module shift_mult_unit #(
  parameter int WIDTH = 8
) (
  input logic             CLK,
  input logic             RESET,
  shift_mult_unit_if.slave bus
);

  localparam int LOG2W = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_stage;
  logic [WIDTH-1:0] shift_nxt;
  logic             out_of_range;

  // One mux stage per amount bit, stage k moves by 2**k positions.
  always_comb begin
    shift_stage = bus.DATA1;
    for (int k = 0; k < LOG2W; k++) begin
      if (bus.DATA2[k]) begin
        case (bus.SHIFTOP)
          2'b00:   shift_stage = shift_stage << (1 << k);
          2'b01:   shift_stage = shift_stage >> (1 << k);
          2'b10:   shift_stage = $signed(shift_stage) >>> (1 << k);
          default: shift_stage = (shift_stage >> (1 << k)) |
                                 (shift_stage << (WIDTH - (1 << k)));
        endcase
      end
    end
  end

  // Amounts >= WIDTH saturate; rotate simply ignores the upper amount bits.
  always_comb begin
    out_of_range = |bus.DATA2[WIDTH-1:LOG2W];
    shift_nxt    = shift_stage;
    if (out_of_range) begin
      case (bus.SHIFTOP)
        2'b00, 2'b01: shift_nxt = '0;
        2'b10:        shift_nxt = {WIDTH{bus.DATA1[WIDTH-1]}};
        default:      shift_nxt = shift_stage;
      endcase
    end
  end

`ifdef PRODUCT_HI_EN
  logic [2*WIDTH-1:0] prod_acc;

  always_comb begin
    prod_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.DATA2[i]) begin
        prod_acc = prod_acc + ({{WIDTH{1'b0}}, bus.DATA1} << i);
      end
    end
  end

  assign bus.MUL_OVF = |bus.PRODUCT_HI;
`else
  // Partial products are truncated as they are added; the upper half is never built.
  logic [WIDTH-1:0] prod_acc;

  always_comb begin
    prod_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.DATA2[i]) begin
        prod_acc = prod_acc + (bus.DATA1 << i);
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.OUT_VALID    <= 1'b0;
      bus.SHIFT_RESULT <= '0;
      bus.PRODUCT      <= '0;
`ifdef PRODUCT_HI_EN
      bus.PRODUCT_HI   <= '0;
`endif
    end else begin
      bus.OUT_VALID <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        bus.SHIFT_RESULT <= shift_nxt;
        bus.PRODUCT      <= prod_acc[WIDTH-1:0];
`ifdef PRODUCT_HI_EN
        bus.PRODUCT_HI   <= prod_acc[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_mult_unit.sv
// Self-checking bench for shift_mult_unit: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_shift_mult_unit;
  localparam int W = 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_shift;
  logic [W-1:0] exp_prod;
  logic         exp_vld;
`ifdef PRODUCT_HI_EN
  logic [W-1:0] exp_hi;
`endif

  shift_mult_unit_if #(.WIDTH(W)) bus ();

  shift_mult_unit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a,
                                             input logic [W-1:0] amt,
                                             input logic [1:0]   op);
    int                  n;
    logic signed [W-1:0] sa;
    logic [2*W-1:0]      dbl;
    n  = int'(amt);
    sa = a;
    ref_shift = '0;
    case (op)
      2'b00: if (n < W) ref_shift = a << n;
      2'b01: if (n < W) ref_shift = a >> n;
      2'b10: begin
        if (n >= W) ref_shift = {W{a[W-1]}};
        else        ref_shift = sa >>> n;
      end
      default: begin
        dbl = {a, a} >> (n % W);
        ref_shift = dbl[W-1:0];
      end
    endcase
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    ref_mul = wa * wb;
  endfunction

  // Drive one cycle of inputs and advance the model at the capturing edge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op);
    logic [2*W-1:0] full;
    @(negedge CLK);
    bus.IN_VALID = v;
    bus.DATA1    = a;
    bus.DATA2    = b;
    bus.SHIFTOP  = op;
    @(posedge CLK);
    if (RESET) begin
      exp_vld = v;
      if (v) begin
        full      = ref_mul(a, b);
        exp_shift = ref_shift(a, b, op);
        exp_prod  = full[W-1:0];
`ifdef PRODUCT_HI_EN
        exp_hi    = full[2*W-1:W];
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bus.IN_VALID = 1'b0;
    bus.DATA1 = '0;
    bus.DATA2 = '0;
    bus.SHIFTOP = 2'b00;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_initial got vld=%b sh=%h pr=%h want 0/00/00",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
    exp_vld = 1'b0; exp_shift = '0; exp_prod = '0;
`ifdef PRODUCT_HI_EN
    exp_hi = '0;
`endif
    @(negedge CLK);
    RESET = 1'b1;
    step(1'b1, 8'h81, 8'h03, 2'b00);
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b1, 8'h08, 8'h83}) begin
      errors++;
      $display("FAIL reset_preload got vld=%b sh=%h pr=%h want 1/08/83",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
    // Assert reset between edges with valid still high.
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_async got vld=%b sh=%h pr=%h want 0/00/00",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_held got vld=%b sh=%h pr=%h want 0/00/00",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
`ifdef PRODUCT_HI_EN
    checks++;
    if ({bus.PRODUCT_HI, bus.MUL_OVF} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_hi got hi=%h ovf=%b want 00/0", bus.PRODUCT_HI, bus.MUL_OVF);
    end
`endif
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    RESET = 1'b1;
    exp_vld = 1'b0; exp_shift = '0; exp_prod = '0;
`ifdef PRODUCT_HI_EN
    exp_hi = '0;
`endif
    @(posedge CLK);
    #1;
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_release got vld=%b sh=%h pr=%h want 0/00/00",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
  endtask

  task automatic test_logical_left();
    step(1'b1, 8'h81, 8'h03, 2'b00);
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b1, 8'h08, 8'h83}) begin
      errors++;
      $display("FAIL lsl_3 got vld=%b sh=%h pr=%h want 1/08/83",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
  endtask

  task automatic test_right_shifts();
    logic [1:0]   ops  [3];
    logic [W-1:0] want [3];
    ops  = '{2'b01, 2'b10, 2'b11};
    want = '{8'h10, 8'hF0, 8'h30};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h81, 8'h03, ops[i]);
      checks++;
      if ({bus.OUT_VALID, bus.SHIFT_RESULT} !== {1'b1, want[i]}) begin
        errors++;
        $display("FAIL right_op%0d got vld=%b sh=%h want 1/%h",
                 ops[i], bus.OUT_VALID, bus.SHIFT_RESULT, want[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] want [4];
    want = '{8'h00, 8'h00, 8'hFF, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h81, 8'd9, 2'(i));
      checks++;
      if (bus.SHIFT_RESULT !== want[i]) begin
        errors++;
        $display("FAIL amt9_op%0d got %h want %h", i, bus.SHIFT_RESULT, want[i]);
      end
    end
    step(1'b1, 8'h81, 8'd0, 2'b10);
    checks++;
    if (bus.SHIFT_RESULT !== 8'h81) begin
      errors++;
      $display("FAIL amt0_asr got %h want 81", bus.SHIFT_RESULT);
    end
  endtask

  task automatic test_multiply();
    logic [W-1:0] r;
    step(1'b1, 8'h10, 8'h10, 2'b00);
    checks++;
    if (bus.PRODUCT !== 8'h00) begin
      errors++;
      $display("FAIL mul_10x10 got %h want 00", bus.PRODUCT);
    end
`ifdef PRODUCT_HI_EN
    checks++;
    if ({bus.PRODUCT_HI, bus.MUL_OVF} !== {8'h01, 1'b1}) begin
      errors++;
      $display("FAIL mul_10x10_hi got hi=%h ovf=%b want 01/1", bus.PRODUCT_HI, bus.MUL_OVF);
    end
`endif
    step(1'b1, 8'hFF, 8'h01, 2'b00);
    checks++;
    if (bus.PRODUCT !== 8'hFF) begin
      errors++;
      $display("FAIL mul_ffx01 got %h want ff", bus.PRODUCT);
    end
`ifdef PRODUCT_HI_EN
    checks++;
    if (bus.MUL_OVF !== 1'b0) begin
      errors++;
      $display("FAIL mul_ffx01_ovf got %b want 0", bus.MUL_OVF);
    end
`endif
    r = 8'($urandom_range(2, 255));
    step(1'b1, 8'h00, r, 2'b01);
    checks++;
    if (bus.PRODUCT !== 8'h00) begin
      errors++;
      $display("FAIL mul_zero got %h want 00", bus.PRODUCT);
    end
    step(1'b1, r, 8'h01, 2'b01);
    checks++;
    if (bus.PRODUCT !== r) begin
      errors++;
      $display("FAIL mul_one got %h want %h", bus.PRODUCT, r);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 8'h5A, 8'h02, 2'b01);
    checks++;
    if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b1, 8'h16, 8'hB4}) begin
      errors++;
      $display("FAIL hold_load got vld=%b sh=%h pr=%h want 1/16/b4",
               bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
      checks++;
      if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {1'b0, 8'h16, 8'hB4}) begin
        errors++;
        $display("FAIL hold_idle%0d got vld=%b sh=%h pr=%h want 0/16/b4",
                 i, bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic         v;
    for (int i = 0; i < 300; i++) begin
      v = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step(v, a, b, 2'($urandom));
      checks++;
      if ({bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT} !== {exp_vld, exp_shift, exp_prod}) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h op=%0d got vld=%b sh=%h pr=%h want %b/%h/%h",
                 i, a, b, bus.SHIFTOP, bus.OUT_VALID, bus.SHIFT_RESULT, bus.PRODUCT,
                 exp_vld, exp_shift, exp_prod);
      end
`ifdef PRODUCT_HI_EN
      checks++;
      if ({bus.PRODUCT_HI, bus.MUL_OVF} !== {exp_hi, (exp_hi != '0)}) begin
        errors++;
        $display("FAIL rand_hi%0d got hi=%h ovf=%b want %h/%b",
                 i, bus.PRODUCT_HI, bus.MUL_OVF, exp_hi, (exp_hi != '0));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_logical_left();
    test_right_shifts();
    test_out_of_range();
    test_multiply();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
